// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one UART transmitter.
//
// Flow: pick a requester, latch its byte, pulse grant, pulse tx_enable,
// then follow tx_busy until the frame ends before arbitrating again.
//
// Ports:
//   clk          system clock
//   rst          asynchronous reset, active-low
//   req          per-requester transmit request (level)
//   req_data     packed bytes, requester i at [i*DATA_W +: DATA_W]
//   grant        one-hot, one-cycle pulse: byte accepted
//   tx_enable    one-cycle start pulse to the UART TX
//   tx_data      byte presented to the UART TX
//   tx_busy      high while the UART TX shifts a frame
//   done         one-cycle pulse: frame finished
//   active_id    index of the current / last granted requester
//   timeout_err  one-cycle pulse: tx_busy never rose after tx_enable
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int DATA_W        = 8,
    parameter int START_TIMEOUT = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         grant,
    output logic                       tx_enable,
    output logic [DATA_W-1:0]          tx_data,
    input  logic                       tx_busy,
    output logic                       done,
    output logic [$clog2(NUM_REQ)-1:0] active_id,
    output logic                       timeout_err
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT) + 1;

    localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);
    localparam logic [ID_W-1:0]  ID_ONE    = ID_W'(1);
    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        START,
        WAIT_BUSY,
        WAIT_DONE
    } state_t;

    state_t state;
    state_t state_d;

    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    rr_ptr_d;
    logic [ID_W-1:0]    active_id_d;
    logic [ID_W-1:0]    pick;
    logic [ID_W-1:0]    next_ptr;
    logic [ID_W:0]      scan_idx;
    logic               found;
    logic [DATA_W-1:0]  tx_data_d;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   cnt_d;
    logic [CNT_W-1:0]   cnt_inc;
    logic               done_d;
    logic               timeout_d;
    logic [NUM_REQ-1:0] grant_vec;
    logic [DATA_W-1:0]  req_bytes [NUM_REQ];

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) begin
            req_bytes[k] = req_data[k*DATA_W +: DATA_W];
        end
    end

    // Scan from rr_ptr upward, wrapping at NUM_REQ (not a power of two
    // in general, so the wrap is an explicit subtract).
    always_comb begin
        found    = 1'b0;
        pick     = rr_ptr;
        scan_idx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr} + (ID_W + 1)'(k);
            if (scan_idx >= NUM_REQ_W) begin
                scan_idx = scan_idx - NUM_REQ_W;
            end
            if (!found && req[scan_idx[ID_W-1:0]]) begin
                found = 1'b1;
                pick  = scan_idx[ID_W-1:0];
            end
        end
    end

    // The serviced requester drops to lowest priority.
    assign next_ptr = (active_id == LAST_ID) ? '0 : active_id + ID_ONE;

    // Saturating increment so the counter can never wrap.
    assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    assign grant_vec = NUM_REQ'(1) << active_id;

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        active_id_d = active_id;
        tx_data_d   = tx_data;
        cnt_d       = cnt;
        done_d      = 1'b0;
        timeout_d   = 1'b0;
        grant       = '0;
        tx_enable   = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    active_id_d = pick;
                    tx_data_d   = req_bytes[pick];
                    state_d     = GRANT;
                end
            end
            GRANT: begin
                grant   = grant_vec;
                state_d = START;
            end
            START: begin
                tx_enable = 1'b1;
                cnt_d     = '0;
                state_d   = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else begin
                    cnt_d = cnt_inc;
                    // Abort on the edge the counter reaches its limit;
                    // the pulse then lands START_TIMEOUT cycles after
                    // the tx_enable cycle.
                    if (cnt_inc == CNT_LIMIT) begin
                        timeout_d = 1'b1;
                        rr_ptr_d  = next_ptr;
                        state_d   = IDLE;
                    end
                end
            end
            WAIT_DONE: begin
                if (!tx_busy) begin
                    done_d   = 1'b1;
                    rr_ptr_d = next_ptr;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            active_id   <= '0;
            tx_data     <= '0;
            cnt         <= '0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_d;
            rr_ptr      <= rr_ptr_d;
            active_id   <= active_id_d;
            tx_data     <= tx_data_d;
            cnt         <= cnt_d;
            done        <= done_d;
            timeout_err <= timeout_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Testbench for uart_tx_arbiter: directed requests, a small UART busy
// model, and a scoreboard monitor checking grants and completions.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ       = 4;
    localparam int DATA_W        = 8;
    localparam int START_TIMEOUT = 16;
    localparam int BUSY_LEN      = 10;
    localparam int WAIT_MAX      = 200;

    logic                       clk = 1'b0;
    logic                       rst;
    logic [NUM_REQ-1:0]         req = '0;
    logic [NUM_REQ*DATA_W-1:0]  req_data = '0;
    logic                       tx_busy = 1'b0;
    logic [NUM_REQ-1:0]         grant;
    logic                       tx_enable;
    logic [DATA_W-1:0]          tx_data;
    logic                       done;
    logic [$clog2(NUM_REQ)-1:0] active_id;
    logic                       timeout_err;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .DATA_W       (DATA_W),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .grant      (grant),
        .tx_enable  (tx_enable),
        .tx_data    (tx_data),
        .tx_busy    (tx_busy),
        .done       (done),
        .active_id  (active_id),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [7:0] data;
    } gnt_t;

    typedef struct {
        int id;
        bit is_to;
    } cmp_t;

    gnt_t gnt_q[$];
    cmp_t cmp_q[$];
    int   busy_q[$];
    gnt_t ge;
    cmp_t ce;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int grant_cnt = 0;
    int cmp_cnt = 0;
    int grant_cyc = -100;
    int en_cyc = -100;
    int fall_cyc = -100;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grants(input int target, input string name);
        int n = 0;
        while (grant_cnt < target && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (grant_cnt < target) begin
            fails++;
            $display("FAIL %s: grants %0d expected %0d", name, grant_cnt, target);
        end
    endtask

    task automatic wait_cmps(input int target, input string name);
        int n = 0;
        while (cmp_cnt < target && n < WAIT_MAX) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (cmp_cnt < target) begin
            fails++;
            $display("FAIL %s: completions %0d expected %0d", name, cmp_cnt, target);
        end
    endtask

    // UART TX model: busy rises right after tx_enable and stays high for
    // a per-frame length (0 = never rises).
    initial begin
        int left;
        int n;
        left = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                tx_busy = 1'b0;
                left = 0;
            end else begin
                if (left > 0) begin
                    left--;
                    if (left == 0) begin
                        tx_busy = 1'b0;
                        fall_cyc = cyc;
                    end
                end
                if (tx_enable) begin
                    n = (busy_q.size() > 0) ? busy_q.pop_front() : BUSY_LEN;
                    if (n > 0) begin
                        tx_busy = 1'b1;
                        left = n;
                    end
                end
            end
        end
    end

    // Monitor / scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (grant != '0) begin
                    if (gnt_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_grant: got %b expected none", grant);
                    end else begin
                        ge = gnt_q.pop_front();
                        check("grant_onehot", 32'(grant), 32'(1) << ge.id);
                        check("grant_tx_data", 32'(tx_data), 32'(ge.data));
                        check("grant_active_id", 32'(active_id), 32'(ge.id));
                    end
                    grant_cyc = cyc;
                    grant_cnt++;
                end
                if (tx_enable) begin
                    check("tx_enable_latency", 32'(cyc - grant_cyc), 32'd1);
                    en_cyc = cyc;
                end
                if (done || timeout_err) begin
                    if (cmp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_completion: done=%b timeout_err=%b expected none",
                                 done, timeout_err);
                    end else begin
                        ce = cmp_q.pop_front();
                        check("cmp_timeout_flag", 32'(timeout_err), 32'(ce.is_to));
                        check("cmp_done_flag", 32'(done), 32'(!ce.is_to));
                        check("cmp_active_id", 32'(active_id), 32'(ce.id));
                        if (ce.is_to) begin
                            check("timeout_latency", 32'(cyc - en_cyc), 32'(START_TIMEOUT));
                        end else begin
                            check("done_latency", 32'(cyc - fall_cyc), 32'd1);
                        end
                    end
                    cmp_cnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_grant", 32'(grant), 32'd0);
        check("rst_tx_enable", 32'(tx_enable), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_active_id", 32'(active_id), 32'd0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_no_grant", 32'(grant_cnt), 32'd0);
        check("idle_no_cmp", 32'(cmp_cnt), 32'd0);

        // Single request on index 2.
        req_data[23:16] = 8'hA5;
        gnt_q.push_back('{id: 2, data: 8'hA5});
        cmp_q.push_back('{id: 2, is_to: 1'b0});
        c0 = cyc;
        req = 4'b0100;
        wait_grants(1, "single_grant");
        check("single_grant_latency", 32'(grant_cyc - c0), 32'd1);
        req = 4'b0000;
        req_data[23:16] = 8'hFF;
        wait_cmps(1, "single_done");
        repeat (2) @(negedge clk);
        check("tx_data_hold", 32'(tx_data), 32'hA5);
        check("active_id_hold", 32'(active_id), 32'd2);

        // Priority rotation: rr_ptr is 3 after serving index 2.
        req_data[31:24] = 8'h33;
        req_data[7:0]   = 8'h30;
        gnt_q.push_back('{id: 3, data: 8'h33});
        cmp_q.push_back('{id: 3, is_to: 1'b0});
        req = 4'b1000;
        wait_grants(2, "rot_grant3");
        req = 4'b0000;
        wait_cmps(2, "rot_done3");
        gnt_q.push_back('{id: 0, data: 8'h30});
        gnt_q.push_back('{id: 3, data: 8'h33});
        cmp_q.push_back('{id: 0, is_to: 1'b0});
        cmp_q.push_back('{id: 3, is_to: 1'b0});
        req = 4'b1001;
        wait_grants(4, "rot_pair");
        req = 4'b0000;
        wait_cmps(4, "rot_pair_done");

        // Round robin with all four requesting from rr_ptr 0.
        req_data = 32'h13121110;
        for (int i = 0; i < 5; i++) begin
            gnt_q.push_back('{id: i % 4, data: 8'h10 + 8'(i % 4)});
            cmp_q.push_back('{id: i % 4, is_to: 1'b0});
        end
        req = 4'b1111;
        wait_grants(9, "rr_grants");
        req = 4'b0000;
        wait_cmps(9, "rr_done");

        // Timeout on index 1, then pending index 3 is served.
        req_data[15:8]  = 8'h5C;
        req_data[31:24] = 8'h3C;
        busy_q.push_back(0);
        busy_q.push_back(BUSY_LEN);
        gnt_q.push_back('{id: 1, data: 8'h5C});
        gnt_q.push_back('{id: 3, data: 8'h3C});
        cmp_q.push_back('{id: 1, is_to: 1'b1});
        cmp_q.push_back('{id: 3, is_to: 1'b0});
        req = 4'b1010;
        wait_grants(10, "to_grant1");
        req = 4'b1000;
        wait_grants(11, "to_grant3");
        req = 4'b0000;
        wait_cmps(11, "to_done3");

        // Reset in the middle of a frame.
        req_data[7:0] = 8'h77;
        gnt_q.push_back('{id: 0, data: 8'h77});
        req = 4'b0001;
        wait_grants(12, "mid_grant");
        req = 4'b0000;
        repeat (5) @(negedge clk);
        check("mid_busy_high", 32'(tx_busy), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_grant", 32'(grant), 32'd0);
        check("mid_rst_tx_enable", 32'(tx_enable), 32'd0);
        check("mid_rst_done", 32'(done), 32'd0);
        check("mid_rst_timeout_err", 32'(timeout_err), 32'd0);
        check("mid_rst_tx_data", 32'(tx_data), 32'd0);
        check("mid_rst_active_id", 32'(active_id), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        check("no_stale_done", 32'(cmp_cnt), 32'd11);
        req_data[7:0] = 8'h42;
        gnt_q.push_back('{id: 0, data: 8'h42});
        cmp_q.push_back('{id: 0, is_to: 1'b0});
        req = 4'b0001;
        wait_grants(13, "post_rst_grant");
        req = 4'b0000;
        wait_cmps(12, "post_rst_done");

        repeat (5) @(negedge clk);
        check("grant_queue_empty", 32'(gnt_q.size()), 32'd0);
        check("cmp_queue_empty", 32'(cmp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
